piso_shift_reg: RTL

- Parametrised parallel-in serial-out shift register. Accepts a WIDTH-bit word over a valid/ready load handshake and presents it one bit at a time on a registered serial output.
- The serial consumer advances the register with a shift-enable input. This allows variable bit rates and stalls.
- Supports MSB/LSB-first ordering, back-to-back words with no idle gap, synchronous abort and a word-done pulse.
- Serves as the serialiser stage in PISO-based datapaths, between a parallel producer and a serial link or bit-rate pacer.

---
 rtl/piso_shift_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register.
// A word is loaded over a valid/ready handshake and presented one bit at a
// time on a registered serial output. The consumer advances it with shift_en.
module piso_shift_reg #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_out_d, ser_valid_d, done_d;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Last bit of the current word is being consumed on this edge.
  assign last_bit   = (state == SHIFT) && (cnt == CNT_LAST) && shift_en;
  assign load_ready = !abort && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign busy       = (state == SHIFT);

  // Bit ordering: the word is shifted towards the output end, so the next
  // bit always sits one position in from the end presented last.
  always_comb begin
    if (LSB_FIRST) begin
      first_bit = load_data[0];
      next_bit  = shreg[1];
      shreg_adv = shreg >> 1;
    end else begin
      first_bit = load_data[WIDTH-1];
      next_bit  = shreg[WIDTH-2];
      shreg_adv = shreg << 1;
    end
  end

  // Next-state and next-output logic; abort outranks shift and load.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    cnt_d       = cnt;
    ser_out_d   = ser_out;
    ser_valid_d = ser_valid;
    done_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d     = SHIFT;
          shreg_d     = load_data;
          cnt_d       = '0;
          ser_out_d   = first_bit;
          ser_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d     = IDLE;
          cnt_d       = '0;
          ser_out_d   = IDLE_LEVEL;
          ser_valid_d = 1'b0;
        end else if (shift_en) begin
          if (cnt == CNT_LAST) begin
            done_d = 1'b1;
            if (accept) begin
              shreg_d     = load_data;
              cnt_d       = '0;
              ser_out_d   = first_bit;
              ser_valid_d = 1'b1;
            end else begin
              state_d     = IDLE;
              cnt_d       = '0;
              ser_out_d   = IDLE_LEVEL;
              ser_valid_d = 1'b0;
            end
          end else begin
            cnt_d     = cnt + CW'(1);
            shreg_d   = shreg_adv;
            ser_out_d = next_bit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      done      <= done_d;
    end
  end

endmodule
